fifo_stream_reader: RTL and testbench

//  Read-side controller for the single-clock circular FIFO. It pops the FIFO through its
//  wr/rd/empty/enable/data_out interface, which has a one-cycle registered read. It presents
//  the words on a valid/ready stream, and generates a last flag every PKT_LEN beats.
//  It sits between the FIFO and a downstream consumer. It sustains 1 beat/cycle, with no

---
 rtl/fifo_stream_reader_pkg.sv | 17 +
 rtl/fifo_stream_obuf.sv | 54 +++++
 rtl/fifo_stream_reader.sv | 117 +++++++++++
 tb/tb_fifo_stream_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int OBUF_DEPTH = 3;

    // Advance a circular pointer over the OBUF_DEPTH-entry buffer.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(OBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_stream_obuf.sv
// Three-entry circular output buffer between the FIFO read pipeline and the stream.
module fifo_stream_obuf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic                  push_ok;
    logic                  pop_ok;

    // The issue rule keeps push away from a full buffer; the guards only
    // protect the pointers if that ever breaks.
    assign push_ok = push && (occ != 2'(OBUF_DEPTH));
    assign pop_ok  = pop && (occ != 2'd0);
    assign dout    = mem[head];

    // Storage: cleared on reset so m_data reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[tail] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave occ unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= 2'd0;
            tail <= 2'd0;
            occ  <= 2'd0;
        end else begin
            if (push_ok) tail <= ptr_inc(tail);
            if (pop_ok)  head <= ptr_inc(head);
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller: pops a registered-read FIFO and presents the words
// as a valid/ready stream with packet framing. Reads are issued from
// registered state only, so m_ready never reaches fifo_rd combinationally.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  fifo_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  idle_pulse
);

    localparam int             BW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0]  BEAT_MAX = BW'(PKT_LEN - 1);

    state_t          state;
    state_t          state_nxt;
    logic            inflight;
    logic [1:0]      occ;
    logic [BW-1:0]   beat_cnt;
    logic [2:0]      pending;
    logic            drained;
    logic            drain_close;
    logic            pop;

    // Words owed to the stream: buffered plus the one read in flight.
    assign pending     = {1'b0, occ} + {2'b0, inflight};
    assign drained     = (occ == 2'd0) && !inflight;
    // Final word of a drain closes whatever packet is open.
    assign drain_close = (state == ST_DRAIN) && (occ == 2'd1) && !inflight;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_last  = m_valid && ((beat_cnt == BEAT_MAX) || drain_close);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; re-enabling during a drain resumes reading at once.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_RUN;
            ST_RUN:   if (!enable) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)       state_nxt = ST_RUN;
                else if (drained) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; reads stop once three words are owed.
    always_comb begin
        fifo_en    = 1'b0;
        fifo_rd    = 1'b0;
        busy       = 1'b0;
        idle_pulse = 1'b0;
        case (state)
            ST_RUN: begin
                fifo_en = 1'b1;
                busy    = 1'b1;
                fifo_rd = !fifo_empty && (pending < 3'(OBUF_DEPTH));
            end
            ST_DRAIN: begin
                fifo_en    = 1'b1;
                busy       = 1'b1;
                idle_pulse = !enable && drained;
            end
            default: ;
        endcase
    end

    // The FIFO returns data one cycle after an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else        inflight <= fifo_rd;
    end

    // Beat counter for framing; a drain-closed packet restarts at beat 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if ((beat_cnt == BEAT_MAX) || drain_close) beat_cnt <= '0;
            else                                       beat_cnt <= beat_cnt + 1'b1;
        end
    end

    fifo_stream_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight),
        .pop  (pop),
        .din  (fifo_data),
        .dout (m_data),
        .occ  (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a behavioural FIFO plus a
// queue-based reference model of words owed to the stream.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          fifo_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          idle_pulse;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .fifo_en(fifo_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .idle_pulse(idle_pulse)
    );

    // FIFO contents, pending writes, and words read but not yet delivered.
    bit [DW-1:0] fq[$];
    bit [DW-1:0] wq[$];
    bit [DW-1:0] eq[$];

    int mode;            // 0 idle, 1 running, 2 draining
    bit rd_d;            // a read was accepted last cycle
    int beat;
    int cyc, deliv, first_cyc, last_cyc, rd_cnt, nlast;
    bit last_was_last;
    int n_vec = 0;
    int n_err = 0;

    int e_out, e_occ;
    bit e_valid, e_rd, e_dc, e_last, e_idle;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from the model state and the current inputs.
    task automatic calc();
        e_out   = eq.size();
        e_occ   = e_out - int'(rd_d);
        e_valid = (e_occ != 0);
        e_rd    = (mode == 1) && !fifo_empty && (e_out < 3);
        e_dc    = (mode == 2) && (e_occ == 1) && !rd_d;
        e_last  = e_valid && ((beat == PL - 1) || e_dc);
        e_idle  = (mode == 2) && !enable && (e_out == 0);
    endtask

    // Model and FIFO advance on the clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq.delete();
            mode = 0;
            rd_d = 1'b0;
            beat = 0;
        end else begin
            calc();
            cyc++;
            if (e_valid && m_ready) begin
                void'(eq.pop_front());
                if (deliv == 0) first_cyc = cyc;
                last_cyc = cyc;
                deliv++;
                beat = ((beat == PL - 1) || e_dc) ? 0 : beat + 1;
            end
            if (e_rd) eq.push_back(fq[0]);
            if (fifo_rd) begin
                rd_cnt++;
                if (fq.size() != 0) fifo_data <= fq.pop_front();
            end
            while (wq.size() != 0) fq.push_back(wq.pop_front());
            fifo_empty <= (fq.size() == 0);
            case (mode)
                0: if (enable) mode = 1;
                1: if (!enable) mode = 2;
                2: if (enable) mode = 1; else if (e_out == 0) mode = 0;
                default: mode = 0;
            endcase
            rd_d = e_rd;
        end
    end

    // Compare every DUT output on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_valid", 32'(m_valid), 0);
            chk("rst_fifo_rd", 32'(fifo_rd), 0);
            chk("rst_m_data", 32'(m_data), 0);
        end else begin
            calc();
            chk("fifo_rd", 32'(fifo_rd), 32'(e_rd));
            chk("fifo_en", 32'(fifo_en), 32'(mode != 0));
            chk("busy", 32'(busy), 32'(mode != 0));
            chk("m_valid", 32'(m_valid), 32'(e_valid));
            chk("m_last", 32'(m_last), 32'(e_last));
            chk("idle_pulse", 32'(idle_pulse), 32'(e_idle));
            if (e_out == 3) chk("rd_when_full", 32'(fifo_rd), 0);
            if (e_valid) chk("m_data", 32'(m_data), 32'(eq[0]));
            if (m_valid && m_ready) begin
                if (m_last) nlast++;
                last_was_last = m_last;
            end
        end
    end

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) wq.push_back(8'(base + i));
    endtask

    task automatic wait_deliv(input int n, input int budget);
        int k = 0;
        while (deliv < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (deliv < n) chk("timeout_deliv", 32'(deliv), 32'(n));
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: eight words streamed back to back with m_ready held high
        m_ready = 1'b1;
        load(8'h10, 8);
        @(posedge clk); #1;
        deliv = 0; nlast = 0;
        enable = 1'b1;
        wait_deliv(8, 40);
        chk("t1_span", 32'(last_cyc - first_cyc), 7);
        chk("t1_lasts", 32'(nlast), 2);

        // 2: alternating backpressure
        deliv = 0;
        load(8'h10, 8);
        k = 0;
        while (deliv < 8 && k < 100) begin
            @(posedge clk); #1;
            m_ready = ~m_ready;
            k++;
        end
        chk("t2_count", 32'(deliv), 8);
        m_ready = 1'b1;
        @(posedge clk); #1;

        // 3: consumer stalled for ten cycles
        m_ready = 1'b0;
        rd_cnt = 0; deliv = 0;
        load(8'h30, 8);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_reads", 32'(rd_cnt), 3);
        m_ready = 1'b1;
        wait_deliv(8, 40);

        // 4: drop enable part-way through and drain
        deliv = 0;
        load(8'h40, 10);
        wait_deliv(6, 40);
        enable = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!idle_pulse && k < 60);
        chk("t4_idle_seen", 32'(idle_pulse), 1);
        chk("t4_drain_last", 32'(last_was_last), 1);
        @(negedge clk);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_fifo_en", 32'(fifo_en), 0);
        chk("t4_pulse_once", 32'(idle_pulse), 0);

        // 5: FIFO runs empty, then a single late write
        @(posedge clk); #1;
        enable = 1'b1;
        k = 0;
        while (!(fifo_empty && eq.size() == 0) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t5_valid_low", 32'(m_valid), 0);
        chk("t5_rd_low", 32'(fifo_rd), 0);
        wq.push_back(8'hA5);
        repeat (2) @(posedge clk);
        #1 chk("t5_not_early", 32'(m_valid), 0);
        @(posedge clk);
        #1;
        chk("t5_valid", 32'(m_valid), 1);
        chk("t5_data", 32'(m_data), 32'h A5);

        // 6: asynchronous reset with two words buffered
        m_ready = 1'b0;
        load(8'h60, 8);
        k = 0;
        do begin
            @(posedge clk); #1;
            calc();
            k++;
        end while (e_occ != 2 && k < 20);
        chk("t6_reach_occ2", 32'(e_occ), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(m_valid), 0);
        chk("t6_data", 32'(m_data), 0);
        chk("t6_last", 32'(m_last), 0);
        chk("t6_rd", 32'(fifo_rd), 0);
        chk("t6_en", 32'(fifo_en), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pulse", 32'(idle_pulse), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Random traffic, backpressure and enable toggling
        repeat (400) begin
            @(posedge clk); #1;
            m_ready = ($urandom % 4) != 0;
            if ($urandom % 3 == 0) wq.push_back(8'($urandom));
            if ($urandom % 50 == 0) enable = ~enable;
        end
        enable = 1'b0;
        m_ready = 1'b1;
        k = 0;
        while (mode != 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("final_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
